scoreboarded_register_file: RTL and testbench

Parametrised successor of the CPU's single-write register file, sized for the pipelined core. It holds `NREGS` general registers of `XLEN` bits with `x0` hardwired to zero. It provides `NUM_RD` asynchronous read ports and one synchronous writeback port. A per-register pending-write scoreboard lets decode detect RAW hazards and stall, and an optional same-cycle writeback-to-read bypass is available.

---
 rtl/scoreboarded_register_file_pkg.sv | 10 +
 rtl/scoreboarded_register_file_scoreboard.sv | 62 ++++++
 rtl/scoreboarded_register_file.sv | 58 +++++
 tb/tb_scoreboarded_register_file.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/scoreboarded_register_file_pkg.sv
// regfile_pkg: default sizing, stack-pointer reset constants and register index type
package regfile_pkg;
    localparam int RF_XLEN = 32;
    localparam int RF_NREGS = 32;
    localparam int RF_CNT_W = 2;
    localparam int RF_SP_INDEX = 2;
    localparam logic [31:0] RF_SP_RESET = 32'h2ffc;
    localparam int RF_AW = $clog2(RF_NREGS);
    typedef logic [RF_AW-1:0] regidx_t;
endpackage

// File: rtl/scoreboarded_register_file_scoreboard.sv
// rf_scoreboard: per-register pending-write counters, issue_ready, read-port busy and sticky wb_err (bypass busy release under REGFILE_WB_BYPASS_EN)
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = RF_NREGS,
    parameter int NUM_RD = 2,
    parameter int CNT_W = RF_CNT_W,
    parameter int AW = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_RD*AW-1:0] rs_addr,
    output logic [NUM_RD-1:0]   rs_busy,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rd,
    output logic                issue_ready,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_rd,
    output logic                wb_err
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [NREGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic wb_err_q, wb_err_d;
    logic wb_hit, issue_acc;
    assign wb_hit = wb_en && wb_rd != '0;
    assign issue_ready = issue_rd == '0 || cnt_q[issue_rd] != CNT_MAX || (wb_hit && wb_rd == issue_rd);
    assign issue_acc = issue_valid && issue_ready && issue_rd != '0;
    assign wb_err = wb_err_q;
    // Counter next state: issue increments, writeback decrements, both to the same register cancel
    always_comb begin
        cnt_d = cnt_q;
        cnt_d[0] = '0;
        for (int r = 1; r < NREGS; r++) begin
            if (issue_acc && issue_rd == AW'(r) && !(wb_hit && wb_rd == AW'(r)))
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            else if (wb_hit && wb_rd == AW'(r) && !(issue_acc && issue_rd == AW'(r)) && cnt_q[r] != '0)
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
        end
        wb_err_d = wb_err_q || (wb_hit && cnt_q[wb_rd] == '0);
    end
    // Per-port busy; with bypass a final outstanding write landing this cycle releases the stall
    always_comb begin
        rs_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rs_busy[k] = cnt_q[rs_addr[k*AW +: AW]] != '0;
`ifdef REGFILE_WB_BYPASS_EN
            if (wb_hit && wb_rd == rs_addr[k*AW +: AW] && cnt_q[wb_rd] == CNT_W'(1) && !(issue_acc && issue_rd == wb_rd))
                rs_busy[k] = 1'b0;
`endif
        end
    end
    // Scoreboard state register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            wb_err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            wb_err_q <= wb_err_d;
        end
    end
endmodule

// File: rtl/scoreboarded_register_file.sv
// scoreboarded_register_file: x0-hardwired register file with async reads, one writeback port, RAW scoreboard; REGFILE_WB_BYPASS_EN adds same-cycle writeback-to-read bypass
module scoreboarded_register_file
    import regfile_pkg::*;
#(
    parameter int XLEN = RF_XLEN,
    parameter int NREGS = RF_NREGS,
    parameter int NUM_RD = 2,
    parameter int CNT_W = RF_CNT_W,
    parameter int SP_INDEX = RF_SP_INDEX,
    parameter logic [XLEN-1:0] SP_RESET = XLEN'(RF_SP_RESET),
    localparam int AW = $clog2(NREGS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*AW-1:0]       rs_addr,
    output logic [NUM_RD*XLEN-1:0]     rs_dout,
    output logic [NUM_RD-1:0]          rs_busy,
    input  logic                       issue_valid,
    input  logic [AW-1:0]              issue_rd,
    output logic                       issue_ready,
    input  logic                       wb_en,
    input  logic [AW-1:0]              wb_rd,
    input  logic [XLEN-1:0]            wb_din,
    output logic                       wb_err,
    output logic [0:NREGS-1][XLEN-1:0] print_reg
);
    logic [0:NREGS-1][XLEN-1:0] rf_q, rf_d;
    assign print_reg = rf_q;
    rf_scoreboard #(.NREGS(NREGS), .NUM_RD(NUM_RD), .CNT_W(CNT_W), .AW(AW)) u_sb (
        .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_busy(rs_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_err(wb_err)
    );
    // Writeback into the array; x0 writes are dropped
    always_comb begin
        rf_d = rf_q;
        if (wb_en && wb_rd != '0) rf_d[wb_rd] = wb_din;
    end
    // Read muxes, optionally forwarding the in-flight writeback
    always_comb begin
        rs_dout = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rs_dout[k*XLEN +: XLEN] = rs_addr[k*AW +: AW] == '0 ? '0 : rf_q[rs_addr[k*AW +: AW]];
`ifdef REGFILE_WB_BYPASS_EN
            if (wb_en && wb_rd != '0 && wb_rd == rs_addr[k*AW +: AW]) rs_dout[k*XLEN +: XLEN] = wb_din;
`endif
        end
    end
    // Array register; reset clears everything then seeds the stack pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_q <= '0;
            rf_q[SP_INDEX] <= SP_RESET;
        end else begin
            rf_q <= rf_d;
        end
    end
endmodule

// File: tb/tb_scoreboarded_register_file.sv
// tb_scoreboarded_register_file: directed stimulus checked every cycle against a behavioural model plus literal expectations
module tb_scoreboarded_register_file;
    logic        clk = 0, reset = 1;
    logic [9:0]  rs_addr = '0;
    logic [63:0] rs_dout;
    logic [1:0]  rs_busy;
    logic        issue_valid = 0, issue_ready;
    logic [4:0]  issue_rd = '0, wb_rd = '0;
    logic        wb_en = 0, wb_err;
    logic [31:0] wb_din = '0;
    logic [0:31][31:0] print_reg;
    int total = 0, bad = 0;
    logic [31:0] mrf [32];
    int          mcnt [32];
    bit          merr;

    scoreboarded_register_file dut (
        .clk(clk), .reset(reset), .rs_addr(rs_addr), .rs_dout(rs_dout), .rs_busy(rs_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_din(wb_din), .wb_err(wb_err), .print_reg(print_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return issue_rd == 0 || mcnt[issue_rd] < 3 || (wb_en && wb_rd == issue_rd);
    endfunction

    function automatic bit m_acc();
        return issue_valid && m_ready() && issue_rd != 0;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mrf[i] <= (i == 2) ? 32'h2ffc : 32'h0;
                mcnt[i] <= 0;
            end
            merr <= 0;
        end else begin
            if (wb_en && wb_rd != 0) begin
                mrf[wb_rd] <= wb_din;
                if (mcnt[wb_rd] == 0) merr <= 1;
            end
            if (!(m_acc() && wb_en && wb_rd == issue_rd)) begin
                if (m_acc()) mcnt[issue_rd] <= mcnt[issue_rd] + 1;
                if (wb_en && wb_rd != 0 && mcnt[wb_rd] > 0) mcnt[wb_rd] <= mcnt[wb_rd] - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("issue_ready", 64'(issue_ready), 64'(m_ready()));
            chk("wb_err", 64'(wb_err), 64'(merr));
            for (int k = 0; k < 2; k++) begin
                int a;
                logic [31:0] ed;
                bit eb;
                a = int'(k == 0 ? rs_addr[4:0] : rs_addr[9:5]);
                ed = a == 0 ? 32'h0 : mrf[a];
                eb = mcnt[a] != 0;
`ifdef REGFILE_WB_BYPASS_EN
                if (wb_en && a != 0 && int'(wb_rd) == a) begin
                    ed = wb_din;
                    if (mcnt[a] == 1 && !(m_acc() && int'(issue_rd) == a)) eb = 0;
                end
`endif
                chk($sformatf("rs_dout[%0d]", k), 64'(rs_dout[k*32 +: 32]), 64'(ed));
                chk($sformatf("rs_busy[%0d]", k), 64'(rs_busy[k]), 64'(eb));
            end
        end
    end

    task automatic step(input bit iv, input int ird, input bit we, input int wrd, input logic [31:0] wd, input int a0, input int a1);
        @(posedge clk);
        #1;
        reset = 0;
        issue_valid = iv;
        issue_rd = 5'(ird);
        wb_en = we;
        wb_rd = 5'(wrd);
        wb_din = wd;
        rs_addr = {5'(a1), 5'(a0)};
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        step(0, 0, 0, 0, 0, 2, 5);
        chk("lit_sp", 64'(rs_dout[31:0]), 64'h2ffc);
        chk("lit_x5_reset", 64'(rs_dout[63:32]), 64'h0);
        chk("lit_busy_reset", 64'(rs_busy), 64'h0);
        chk("lit_ready_reset", 64'(issue_ready), 64'h1);
        step(1, 5, 0, 0, 0, 5, 0);
        step(0, 0, 1, 5, 32'hdeadbeef, 5, 0);
        step(0, 0, 0, 0, 0, 5, 0);
        chk("lit_x5_written", 64'(rs_dout[31:0]), 64'hdeadbeef);
        chk("lit_x5_free", 64'(rs_busy[0]), 64'h0);
        step(0, 0, 1, 0, 32'h1234, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("lit_x0_zero", 64'(rs_dout[31:0]), 64'h0);
        chk("lit_x0_ready", 64'(issue_ready), 64'h1);
        chk("lit_x0_busy", 64'(rs_busy[0]), 64'h0);
        repeat (3) step(1, 7, 0, 0, 0, 7, 0);
        step(1, 7, 0, 0, 0, 7, 0);
        chk("lit_x7_full", 64'(issue_ready), 64'h0);
        chk("lit_x7_busy", 64'(rs_busy[0]), 64'h1);
        step(1, 7, 1, 7, 32'h7, 7, 0);
        chk("lit_x7_ready_wb", 64'(issue_ready), 64'h1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 7, 32'h8, 7, 0);
        step(0, 0, 0, 0, 0, 7, 0);
        chk("lit_x7_drained", 64'(rs_busy[0]), 64'h0);
        chk("lit_x7_data", 64'(rs_dout[31:0]), 64'h8);
        chk("lit_no_err", 64'(wb_err), 64'h0);
        step(1, 3, 0, 0, 0, 3, 0);
        step(0, 0, 1, 3, 32'h55, 3, 0);
`ifdef REGFILE_WB_BYPASS_EN
        chk("lit_x3_bypass", 64'(rs_dout[31:0]), 64'h55);
        chk("lit_x3_bypass_busy", 64'(rs_busy[0]), 64'h0);
`else
        chk("lit_x3_old", 64'(rs_dout[31:0]), 64'h0);
        chk("lit_x3_busy", 64'(rs_busy[0]), 64'h1);
`endif
        step(0, 0, 0, 0, 0, 3, 0);
        chk("lit_x3_new", 64'(rs_dout[31:0]), 64'h55);
        chk("lit_x3_free", 64'(rs_busy[0]), 64'h0);
        step(0, 0, 1, 9, 32'ha5a5, 9, 0);
        step(0, 0, 0, 0, 0, 9, 0);
        chk("lit_err_set", 64'(wb_err), 64'h1);
        chk("lit_x9_data", 64'(rs_dout[31:0]), 64'ha5a5);
        step(1, 11, 0, 0, 0, 0, 0);
        chk("lit_err_sticky", 64'(wb_err), 64'h1);
        step(1, 4, 0, 0, 0, 4, 0);
        @(posedge clk);
        #1;
        reset = 1;
        issue_valid = 1;
        issue_rd = 5'd6;
        wb_en = 1;
        wb_rd = 5'd6;
        wb_din = 32'hffff;
        step(0, 0, 0, 0, 0, 6, 4);
        chk("lit_rst_x6", 64'(rs_dout[31:0]), 64'h0);
        chk("lit_rst_busy", 64'(rs_busy), 64'h0);
        chk("lit_rst_err", 64'(wb_err), 64'h0);
        chk("lit_rst_pr6", 64'(print_reg[6]), 64'h0);
        chk("lit_rst_x9", 64'(print_reg[9]), 64'h0);
        step(0, 11, 0, 0, 0, 2, 9);
        chk("lit_rst_sp", 64'(rs_dout[31:0]), 64'h2ffc);
        chk("lit_rst_ready", 64'(issue_ready), 64'h1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
